fp_div_issue_queue: RTL and testbench

Operand buffer and issue controller that sits directly upstream of the single-precision `divider`. It accepts IEEE-754 operand pairs with a tag over a valid/ready interface and queues them in a FIFO. It launches one divide at a time on the divider's `start`/`busy`/`valid` handshake and returns each quotient, with its tag and a divide-by-zero flag, over a valid/ready result interface.

---
 rtl/fp_div_pkg.sv | 20 ++
 rtl/fp_div_issue_queue_sync_fifo.sv | 53 +++++
 rtl/fp_div_issue_queue.sv | 130 +++++++++++++
 tb/tb_fp_div_issue_queue.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the FP divider
// issue queue slice.
package fp_div_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  function automatic logic is_zero(
    input logic [FP_W-1:0] fp
  );
    return fp[FP_W-2:0] == '0;
  endfunction

endpackage

// File: rtl/fp_div_issue_queue_sync_fifo.sv
// Synchronous FIFO with occupancy count;
// head entry is visible combinationally on rdata.
module sync_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == DEPTH[AW:0];
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_div_issue_queue.sv
// Operand queue and one-at-a-time issue control
// in front of the single-precision divider.
module fp_div_issue_queue
  import fp_div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   div_start,
  output logic [31:0]            div_dividened,
  output logic [31:0]            div_divisor,
  input  logic                   div_busy,
  input  logic                   div_valid,
  input  logic [31:0]            div_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [TAG_W-1:0]       res_tag,
  output logic                   res_dz,
  output logic [$clog2(DEPTH):0] count
);

  localparam int EW = 2*FP_W + TAG_W;

  state_t            state;
  state_t            state_nx;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [EW-1:0]     wdata;
  logic [EW-1:0]     rdata;
  logic [FP_W-1:0]   head_a;
  logic [FP_W-1:0]   head_b;
  logic [TAG_W-1:0]  head_tag;
  logic [TAG_W-1:0]  tag_q;
  logic              dz_q;

  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign wdata    = {in_a, in_b, in_tag};
  assign {head_a, head_b, head_tag} = rdata;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !div_busy) begin
          state_nx = ISSUE;
          pop      = 1'b1;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (div_valid) state_nx = HOLD;
      end
      HOLD: begin
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // pop only happens on the IDLE->ISSUE edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_start     <= 1'b0;
      div_dividened <= '0;
      div_divisor   <= '0;
      tag_q         <= '0;
      dz_q          <= 1'b0;
    end else begin
      div_start <= pop;
      if (pop) begin
        div_dividened <= head_a;
        div_divisor   <= head_b;
        tag_q         <= head_tag;
        dz_q          <= is_zero(head_b);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_dz    <= 1'b0;
    end else if (state == WAIT && div_valid) begin
      res_valid <= 1'b1;
      res_data  <= div_out;
      res_tag   <= tag_q;
      res_dz    <= dz_q;
    end else if (state == HOLD && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_div_issue_queue.sv
// Directed bench for fp_div_issue_queue with a
// fixed-latency behavioural divider model.
module tb_fp_div_issue_queue;

  localparam int LAT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        div_start;
  logic [31:0] div_dividened;
  logic [31:0] div_divisor;
  logic        div_busy = 1'b0;
  logic        div_valid = 1'b0;
  logic [31:0] div_out = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic        res_dz;
  logic [2:0]  count;

  logic        hold_busy = 1'b0;
  logic        inj = 1'b0;
  logic [31:0] inj_data = '0;
  logic        active = 1'b0;
  int          cnt = 0;
  logic [31:0] qp = '0;

  int checks = 0;
  int failures = 0;

  fp_div_issue_queue #(
    .DEPTH (4),
    .TAG_W (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_tag        (in_tag),
    .div_start     (div_start),
    .div_dividened (div_dividened),
    .div_divisor   (div_divisor),
    .div_busy      (div_busy),
    .div_valid     (div_valid),
    .div_out       (div_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_tag       (res_tag),
    .res_dz        (res_dz),
    .count         (count)
  );

  always #5 clk = ~clk;

  // known quotients; other operands get a fake a^b
  function automatic logic [31:0] model_q(
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (a == 32'h40C0_0000 && b == 32'h4000_0000)
      return 32'h4040_0000;
    if (a == 32'h3F80_0000 && b == 32'h8000_0000)
      return 32'hFF80_0000;
    return a ^ b;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      active    = 1'b0;
      cnt       = 0;
      div_valid = 1'b0;
      div_out   = '0;
    end else begin
      div_valid = 1'b0;
      if (active) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          active    = 1'b0;
          div_valid = 1'b1;
          div_out   = qp;
        end
      end else if (div_start) begin
        active = 1'b1;
        cnt    = LAT;
        qp     = model_q(div_dividened, div_divisor);
      end
      if (inj) begin
        div_valid = 1'b1;
        div_out   = inj_data;
      end
    end
    div_busy = hold_busy | active;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  t
  );
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    check("res_valid_wait", 64'(res_valid), 64'd1);
  endtask

  task automatic take(
    output logic [31:0] d,
    output logic [3:0]  t,
    output logic        dz
  );
    wait_valid();
    d  = res_data;
    t  = res_tag;
    dz = res_dz;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  logic [31:0] d;
  logic [3:0]  t;
  logic        dz;
  logic [31:0] fa [5];
  logic [31:0] fb [5];
  logic [31:0] hd;
  logic [3:0]  ht;
  int          starts;
  logic        moved;
  logic        acc;
  int          n;

  initial begin
    tick();
    tick();
    check("rst_start", 64'(div_start), 64'd0);
    check("rst_dvd", 64'(div_dividened), 64'd0);
    check("rst_dvs", 64'(div_divisor), 64'd0);
    check("rst_rvalid", 64'(res_valid), 64'd0);
    check("rst_rdata", 64'(res_data), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_inready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    tick();

    // single op
    push(32'h40C0_0000, 32'h4000_0000, 4'd3);
    check("s_count", 64'(count), 64'd1);
    check("s_start0", 64'(div_start), 64'd0);
    tick();
    check("s_start1", 64'(div_start), 64'd1);
    check("s_dvd", 64'(div_dividened), 64'h40C0_0000);
    check("s_dvs", 64'(div_divisor), 64'h4000_0000);
    check("s_count0", 64'(count), 64'd0);
    tick();
    check("s_start2", 64'(div_start), 64'd0);
    check("s_dvd_hold", 64'(div_dividened), 64'h40C0_0000);
    take(d, t, dz);
    check("s_data", 64'(d), 64'h4040_0000);
    check("s_tag", 64'(t), 64'd3);
    check("s_dz", 64'(dz), 64'd0);

    // fill with divider busy
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      fa[i] = 32'h3F80_0000 + 32'(i);
      fb[i] = 32'h4000_0000 + 32'(i << 8);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a   = fa[i];
      in_b   = fb[i];
      in_tag = 4'(i);
      tick();
    end
    check("f_count", 64'(count), 64'd4);
    check("f_inready", 64'(in_ready), 64'd0);
    check("f_nostart", 64'(div_start), 64'd0);
    hold_busy = 1'b0;
    n = 0;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    check("f_accept4", 64'(acc), 64'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      take(d, t, dz);
      check($sformatf("f_tag%0d", i), 64'(t), 64'(i));
      check($sformatf("f_data%0d", i), 64'(d),
            64'(model_q(fa[i], fb[i])));
    end

    // backpressure
    push(32'h4100_0000, 32'h3F00_0005, 4'd5);
    push(32'h4200_0000, 32'h3F00_0006, 4'd6);
    check("b_count", 64'(count), 64'd1);
    wait_valid();
    hd = res_data;
    ht = res_tag;
    starts = 0;
    moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (div_start) starts++;
      if (!res_valid || res_data !== hd || res_tag !== ht)
        moved = 1'b1;
    end
    check("b_stable", 64'(moved), 64'd0);
    check("b_nostart", 64'(starts), 64'd0);
    check("b_data", 64'(hd), 64'h4100_0000 ^ 64'h3F00_0005);
    check("b_tag", 64'(ht), 64'd5);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("b_rv_clr", 64'(res_valid), 64'd0);
    check("b_start_e1", 64'(div_start), 64'd0);
    tick();
    check("b_start_e2", 64'(div_start), 64'd1);
    take(d, t, dz);
    check("b_tag6", 64'(t), 64'd6);

    // divide by negative zero
    push(32'h3F80_0000, 32'h8000_0000, 4'd7);
    take(d, t, dz);
    check("z_dz", 64'(dz), 64'd1);
    check("z_data", 64'(d), 64'hFF80_0000);
    check("z_tag", 64'(t), 64'd7);

    // push and pop on the same edge
    hold_busy = 1'b1;
    tick();
    push(32'h4080_0000, 32'h3F80_0000, 4'd8);
    check("p_count1", 64'(count), 64'd1);
    hold_busy = 1'b0;
    push(32'h4090_0000, 32'h3F80_0000, 4'd9);
    check("p_count_same", 64'(count), 64'd1);
    check("p_start", 64'(div_start), 64'd1);
    check("p_dvd", 64'(div_dividened), 64'h4080_0000);
    take(d, t, dz);
    check("p_tag8", 64'(t), 64'd8);
    take(d, t, dz);
    check("p_tag9", 64'(t), 64'd9);
    check("p_data9", 64'(d), 64'h4090_0000 ^ 64'h3F80_0000);

    // reset during WAIT
    push(32'h4000_0000, 32'h4000_0000, 4'd10);
    push(32'h4100_0000, 32'h4000_0000, 4'd11);
    tick();
    tick();
    check("r_pre_count", 64'(count), 64'd1);
    rst = 1'b0;
    #1;
    check("r_start", 64'(div_start), 64'd0);
    check("r_dvd", 64'(div_dividened), 64'd0);
    check("r_dvs", 64'(div_divisor), 64'd0);
    check("r_rvalid", 64'(res_valid), 64'd0);
    check("r_count", 64'(count), 64'd0);
    check("r_inready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    tick();
    inj_data = 32'h1234_5678;
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check("r_late_rv", 64'(res_valid), 64'd0);
    tick();
    check("r_late_rv2", 64'(res_valid), 64'd0);
    check("r_late_rd", 64'(res_data), 64'd0);
    check("r_late_st", 64'(div_start), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
